// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interruptor: register offsets,
// register file layout and the byte-merge helper used by bus writes.
package clint_pkg;

  // constants
  localparam logic [15:0] clint_msip      = 16'h0000;
  localparam logic [15:0] clint_mtimecmp  = 16'h4000;
  localparam logic [15:0] clint_mtimecmph = 16'h4004;
  localparam logic [15:0] clint_mtime     = 16'hBFF8;
  localparam logic [15:0] clint_mtimeh    = 16'hBFFC;

  // wires
  typedef struct packed {
    logic        msip;
    logic [63:0] mtimecmp;
    logic [63:0] mtime;
  } clint_reg_type;

  localparam clint_reg_type init_clint_reg = '{
    msip:     1'b0,
    mtimecmp: 64'hFFFF_FFFF_FFFF_FFFF,
    mtime:    64'h0
  };

  typedef enum logic {
    BUS_IDLE,
    BUS_RESP
  } bus_state_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  strb);
    merge_bytes = old;
    for (int i = 0; i < 4; i++)
      if (strb[i]) merge_bytes[8*i +: 8] = wdata[8*i +: 8];
  endfunction

endpackage

// File: rtl/clint_tick.sv
// Prescaler: pulses tick once every CLK_DIV cycles.
module clint_tick #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [15:0] div_cnt;

  assign tick = (div_cnt == 16'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 16'd1;
  end

endmodule

// File: rtl/clint.sv
// Core-local interruptor: mtime/mtimecmp/msip registers on the data bus,
// with registered msip/mtip level interrupts for the CSR unit.
module clint
  import clint_pkg::*;
#(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        msip,
  output logic        mtip,
  output logic [63:0] mtime
);

  bus_state_t    state_q, state_d;
  clint_reg_type r_q, r_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          mtip_q;
  logic          tick, req, wr, mt_wr;
  logic [15:0]   off;

  clint_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign off   = {mem_addr[15:2], 2'b00};
  assign req   = (state_q == BUS_IDLE) && mem_valid;
  assign wr    = req && !mem_instr && (mem_wstrb != 4'b0000);
  assign mt_wr = wr && ((off == clint_mtime) || (off == clint_mtimeh));

  always_comb begin
    state_d = state_q;
    case (state_q)
      BUS_IDLE: if (mem_valid) state_d = BUS_RESP;
      BUS_RESP: state_d = BUS_IDLE;
      default:  state_d = BUS_IDLE;
    endcase
  end

  always_comb begin
    rdata_d = '0;
    case (off)
      clint_msip:      rdata_d = {31'b0, r_q.msip};
      clint_mtimecmp:  rdata_d = r_q.mtimecmp[31:0];
      clint_mtimecmph: rdata_d = r_q.mtimecmp[63:32];
      clint_mtime:     rdata_d = r_q.mtime[31:0];
      clint_mtimeh:    rdata_d = r_q.mtime[63:32];
      default:         rdata_d = '0;
    endcase
  end

  // A bus write to either mtime half suppresses that cycle's increment entirely.
  always_comb begin
    r_d = r_q;
    if (tick && !mt_wr) r_d.mtime = r_q.mtime + 64'd1;
    if (wr) begin
      case (off)
        clint_msip:      if (mem_wstrb[0]) r_d.msip = mem_wdata[0];
        clint_mtimecmp:  r_d.mtimecmp[31:0]  = merge_bytes(r_q.mtimecmp[31:0],  mem_wdata, mem_wstrb);
        clint_mtimecmph: r_d.mtimecmp[63:32] = merge_bytes(r_q.mtimecmp[63:32], mem_wdata, mem_wstrb);
        clint_mtime:     r_d.mtime[31:0]     = merge_bytes(r_q.mtime[31:0],     mem_wdata, mem_wstrb);
        clint_mtimeh:    r_d.mtime[63:32]    = merge_bytes(r_q.mtime[63:32],    mem_wdata, mem_wstrb);
        default:         ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BUS_IDLE;
      r_q     <= init_clint_reg;
      rdata_q <= '0;
      mtip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      mtip_q  <= (r_q.mtime >= r_q.mtimecmp);
      if (req) rdata_q <= rdata_d;
    end
  end

  assign mem_ready = (state_q == BUS_RESP);
  assign mem_rdata = mem_ready ? rdata_q : '0;
  assign msip      = r_q.msip;
  assign mtip      = mtip_q;
  assign mtime     = r_q.mtime;

endmodule

// File: tb/tb_clint.sv
// Scoreboard bench for clint: a CLK_DIV=1 instance carries the bus tests,
// a CLK_DIV=4 instance checks write-vs-tick collision timing.
module tb_clint;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0, mem_valid4 = 1'b0;
  logic        mem_instr = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready, mem_ready4;
  logic [31:0] mem_rdata, mem_rdata4;
  logic        msip, msip4, mtip, mtip4;
  logic [63:0] mtime, mtime4;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        is_rd;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  clint #(.CLK_DIV(1)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .msip(msip), .mtip(mtip), .mtime(mtime)
  );

  clint #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .mem_valid(mem_valid4), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready4), .mem_rdata(mem_rdata4), .msip(msip4), .mtip(mtip4), .mtime(mtime4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one request at the current negedge; returns at the negedge of the response cycle.
  task automatic bus_req(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic instr, input logic [31:0] exp);
    exp_t e;
    e.is_rd = instr || (strb == 4'b0000);
    e.data  = exp;
    sb.push_back(e);
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = strb;
    mem_instr = instr;
    @(negedge clk);
    mem_valid = 1'b0;
    mem_wstrb = '0;
    mem_instr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && mem_ready) begin
      if (sb.size() == 0) chk("unexpected_ready", 64'(mem_ready), 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        if (e.is_rd) chk("rdata", 64'(mem_rdata), 64'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] p;
    int n;
    repeat (2) @(negedge clk);
    chk("rst_mtime", mtime, 64'd0);
    chk("rst_mtip", 64'(mtip), 64'd0);
    chk("rst_msip", 64'(msip), 64'd0);
    chk("rst_ready", 64'(mem_ready), 64'd0);
    chk("rst_rdata", 64'(mem_rdata), 64'd0);
    rst = 1'b0;

    repeat (10) @(negedge clk);
    chk("idle_mtime", mtime, 64'd10);
    chk("idle_mtip", 64'(mtip), 64'd0);
    chk("idle_msip", 64'(msip), 64'd0);

    // msip set / read / clear
    bus_req(32'h0000, 32'h1, 4'hF, 1'b0, 32'h0);
    chk("msip_set", 64'(msip), 64'd1);
    @(negedge clk);
    bus_req(32'h0000, 32'h0, 4'h0, 1'b0, 32'h1);
    @(negedge clk);
    bus_req(32'h0000, 32'h0, 4'hF, 1'b0, 32'h0);
    chk("msip_clr", 64'(msip), 64'd0);
    @(negedge clk);

    // byte strobes, unmapped offset, addr[1:0] ignored, instr fetch is a read
    bus_req(32'h4000, 32'hAABBCCDD, 4'b0100, 1'b0, 32'h0);
    @(negedge clk);
    bus_req(32'h4000, 32'h0, 4'h0, 1'b0, 32'hFFBBFFFF);
    @(negedge clk);
    bus_req(32'h1234, 32'h0, 4'h0, 1'b0, 32'h0);
    @(negedge clk);
    bus_req(32'h4003, 32'h0, 4'h0, 1'b0, 32'hFFBBFFFF);
    @(negedge clk);
    bus_req(32'h4004, 32'h0, 4'hF, 1'b1, 32'hFFFFFFFF);
    @(negedge clk);
    bus_req(32'h4004, 32'h0, 4'h0, 1'b0, 32'hFFFFFFFF);
    @(negedge clk);

    // mtip rises the cycle after mtime reaches mtimecmp
    bus_req(32'hBFF8, 32'h0, 4'hF, 1'b0, 32'h0);
    chk("mtime_wr0", mtime, 64'd0);
    @(negedge clk);
    bus_req(32'h4004, 32'h0, 4'hF, 1'b0, 32'h0);
    @(negedge clk);
    bus_req(32'h4000, 32'h20, 4'hF, 1'b0, 32'h0);
    @(negedge clk);
    n = 0;
    while (mtime != 64'h1F && n < 200) begin @(negedge clk); n++; end
    chk("cmp_sync", mtime, 64'h1F);
    chk("mtip_below", 64'(mtip), 64'd0);
    @(negedge clk);
    chk("mtime_eq", mtime, 64'h20);
    chk("mtip_eq_lag", 64'(mtip), 64'd0);
    @(negedge clk);
    chk("mtip_rise", 64'(mtip), 64'd1);
    repeat (5) @(negedge clk);
    chk("mtip_hold", 64'(mtip), 64'd1);

    // low-to-high carry, then full 64-bit wrap
    bus_req(32'hBFF8, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0);
    chk("carry_pre", mtime, 64'h0000_0000_FFFF_FFFF);
    @(negedge clk);
    chk("carry", mtime, 64'h0000_0001_0000_0000);
    bus_req(32'hBFFC, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0);
    chk("hi_wr_noinc", mtime, 64'hFFFF_FFFF_0000_0000);
    @(negedge clk);
    bus_req(32'hBFF8, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0);
    chk("all_ones", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    chk("wrap", mtime, 64'd0);
    chk("mtip_at_wrap", 64'(mtip), 64'd1);
    @(negedge clk);
    chk("mtip_fall", 64'(mtip), 64'd0);

    // CLK_DIV=4: mtime write colliding with tick
    p = mtime4;
    n = 0;
    while (mtime4 == p && n < 20) begin @(negedge clk); n++; end
    chk("div4_sync", 64'(mtime4 != p), 64'd1);
    repeat (3) @(negedge clk);
    mem_valid4 = 1'b1;
    mem_addr   = 32'hBFF8;
    mem_wdata  = 32'h100;
    mem_wstrb  = 4'hF;
    @(negedge clk);
    mem_valid4 = 1'b0;
    mem_wstrb  = '0;
    chk("div4_wr", mtime4, 64'h100);
    repeat (3) @(negedge clk);
    chk("div4_hold", mtime4, 64'h100);
    @(negedge clk);
    chk("div4_inc", mtime4, 64'h101);

    repeat (2) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clint.md
# clint

Core-local interruptor feeding the CSR unit's `msip`, `mtip` and `mtime` inputs. Holds the 64-bit real-time counter `mtime`, the 64-bit compare register `mtimecmp` and the software-interrupt bit `msip`, all memory-mapped on the core's data bus. Generates registered level interrupts that the CSR unit samples directly.

## Interface
- `CLK_DIV`, 1: `mtime` increments once every `CLK_DIV` clock cycles. Legal range is 1..65535.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset. All state is cleared on assertion.
- `mem_valid` in 1: single-cycle request strobe.
- `mem_instr` in 1: instruction fetch. Such a request is treated as a read.
- `mem_addr` in 32: byte address. Only `[15:0]` is decoded; the interconnect has already decoded the region.
- `mem_wdata` in 32: write data.
- `mem_wstrb` in 4: byte strobes. Any nonzero value makes the request a write; zero makes it a read.
- `mem_ready` out 1: response strobe.
- `mem_rdata` out 32: read data, valid when `mem_ready` is 1 and 0 otherwise.
- `msip` out 1: software interrupt pending.
- `mtip` out 1: timer interrupt pending.
- `mtime` out 64: current counter value.

## Operation
Register map, by word offset:
- 0x0000: `msip`. Bit 0 is read/write; bits [31:1] read 0.
- 0x4000 / 0x4004: `mtimecmp[31:0]` / `mtimecmp[63:32]`.
- 0xBFF8 / 0xBFFC: `mtime[31:0]` / `mtime[63:32]`.
- Any other offset reads 0, ignores writes, and still responds.

Access rules:
- `mem_addr[1:0]` is ignored.
- Writes merge per byte according to `mem_wstrb`.

Bus FSM, two states:
- IDLE: `mem_valid`=1 → capture the request, perform the write in the same edge, latch read data → go to RESP.
- RESP: `mem_ready`=1 for exactly one cycle → go to IDLE.
- A `mem_valid` that arrives in RESP is ignored. The master must not issue back-to-back requests.

Prescaler:
- Counter `div_cnt` runs 0..`CLK_DIV`-1.
- `tick`=1 when `div_cnt`==`CLK_DIV`-1; `div_cnt` then wraps to 0.
- `CLK_DIV`=1 gives `tick` every cycle.

`mtime` update:
- `mtime` += 1 on `tick`, modulo 2^64. 0xFFFF_FFFF_FFFF_FFFF wraps to 0 with no flag.
- The carry from the low word to the high word happens in the same cycle.

Simultaneous events:
- A bus write to either `mtime` half in the same cycle as `tick` wins: the written value is stored, with no increment that cycle.
- Only the written half takes write data; the other half keeps its current value and is not incremented.

Interrupt outputs:
- `mtip` is registered: `mtip` <= (`mtime` >= `mtimecmp`), using an unsigned 64-bit compare of the current register values.
- The software updates `mtimecmp` one half at a time. Transient `mtip` glitches during that sequence are permitted.
- `msip` is driven directly from its register bit.

## Timing
Reset values:
- `mtime`=0, `mtimecmp`=0xFFFF_FFFF_FFFF_FFFF, `msip`=0, `mtip`=0.
- `div_cnt`=0, FSM=IDLE, `mem_ready`=0, `mem_rdata`=0.

Latency:
- Read: request cycle N → `mem_ready`/`mem_rdata` in cycle N+1. The data is the register value sampled at edge N, before any tick in N.
- Write: the register updates at the end of cycle N. `mem_ready` is 1 in N+1.
- `mtip`: reflects a new `mtime` or `mtimecmp` one cycle after that register changes.
- `msip`: reflects a write in cycle N+1.

Other rules:
- `mtime` read torn across halves is the software's problem; the hardware does no snapshotting.
- Reset mid-transaction forces IDLE with no response. Any write not yet clocked is lost.

## Structure
Shared package contents:
- In `constants`: `clint_msip` (0x0000), `clint_mtimecmp` (0x4000), `clint_mtimecmph` (0x4004), `clint_mtime` (0xBFF8), `clint_mtimeh` (0xBFFC).
- In `wires`: `clint_reg_type` struct holding `msip`, `mtimecmp`, `mtime`, and `init_clint_reg`.

Sub-module:
- `clint_tick` is the prescaler, with parameter `CLK_DIV`, ports `clk`/`rst`/`tick`.
- Everything else lives in `clint`.

## Test plan
- Reset, then idle 10 cycles with `CLK_DIV`=1 → `mtime`=10, `mtip`=0, `msip`=0, `mem_ready` never asserted.
- Write 0x0000_0001 to 0x0000 → `msip`=1 one cycle later. Read 0x0000 → `mem_rdata`=0x1. Write 0 → `msip`=0.
- Write `mtimecmp`=0x0000_0000_0000_0020 (high word first), `CLK_DIV`=1 → `mtip` rises in the cycle after `mtime` reaches 0x20 and stays 1.
- Write `mtime` low word 0xFFFF_FFFF and high word 0xFFFF_FFFF, then let it tick → `mtime` wraps to 0 and the low-to-high carry is observed at 0x0000_0001_0000_0000 crossing.
- `CLK_DIV`=4: write `mtime` low 0x100 in the same cycle as `tick` → the register holds 0x100, increments to 0x101 exactly 4 cycles later.
- Byte-strobe write 0xAABBCCDD with `wstrb`=0b0100 to 0x4000 on reset `mtimecmp` → the low word reads 0xFFBBFFFF. Read of 0x1234 → 0 with `mem_ready` 1 cycle later.
